// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the buffered UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PARITY_EVEN  = 1'b0;
    localparam logic PARITY_ODD   = 1'b1;
    localparam int   MIN_DATA_LEN = 5;

    // Out-of-range lengths saturate into the legal window.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        if (len < 4'(MIN_DATA_LEN)) return 4'(MIN_DATA_LEN);
        if (len > max_len)          return max_len;
        return len;
    endfunction

    function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                                 input logic [3:0]  len,
                                                 input logic        par_en,
                                                 input logic        two_stop);
        return clks_per_bit * (32'd2 + 32'(len) + 32'(par_en) + 32'(two_stop));
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Brief    : Single-clock show-ahead FIFO with occupancy count, full and empty.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int c_addr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [c_addr_w-1:0] wr_ptr_q;
    logic [c_addr_w-1:0] rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                w_push;
    logic                w_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffered
// Brief    : FIFO-buffered UART transmitter with run-time frame format.
//            Optional line-break support is built when UART_TX_BREAK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int MAX_DATA_LEN = 9,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    tx_clk,
    input  logic                    rst,
    input  logic [MAX_DATA_LEN-1:0] parallel_datain,
    input  logic                    send,
    input  logic [3:0]              data_len,
    input  logic                    parity_en,
    input  logic                    parity_type,
    input  logic                    two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic                    send_break,
`endif
    output logic                    tx_serialout,
    output logic                    tx_busy,
    output logic                    tx_done,
    output logic                    fifo_full,
    output logic                    fifo_empty,
    output logic [CNT_W-1:0]        fifo_count,
    output logic                    overflow
);

    localparam int                  c_baud_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);

    uart_state_e              state_q, state_d;
    logic [c_baud_w-1:0]      baud_q, baud_d;
    logic [3:0]               bit_q, bit_d;
    logic                     stop_q, stop_d;
    logic [MAX_DATA_LEN-1:0]  shift_q, shift_d;
    logic [3:0]               len_q, len_d;
    logic                     par_en_q, par_en_d;
    logic                     par_bit_q, par_bit_d;
    logic                     two_stop_q, two_stop_d;
    logic                     overflow_q, overflow_d;
`ifdef UART_TX_BREAK_EN
    logic                     brk_q, brk_d;
`endif

    logic [MAX_DATA_LEN-1:0]  w_fifo_rdata;
    logic [3:0]               w_len;
    logic                     w_par_xor;
    logic                     w_bit_end;
    logic                     w_last_stop;
    logic                     w_idle_ok;
    logic                     w_pop;

    uart_sync_fifo #(
        .WIDTH (MAX_DATA_LEN),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i   (tx_clk),
        .rst_i   (rst),
        .push_i  (send),
        .wdata_i (parallel_datain),
        .pop_i   (w_pop),
        .rdata_o (w_fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign w_len       = clamp_len(data_len, 4'(MAX_DATA_LEN));
    assign w_bit_end   = (baud_q == c_baud_last);
    assign w_last_stop = !two_stop_q || stop_q;
    assign overflow    = overflow_q;

`ifdef UART_TX_BREAK_EN
    // After a break, the release bit time must expire before the next pop.
    assign w_idle_ok = !send_break && (!brk_q || w_bit_end);
`else
    assign w_idle_ok = 1'b1;
`endif

    assign w_pop = ((state_q == ST_IDLE) && !fifo_empty && w_idle_ok) ||
                   ((state_q == ST_STOP) && w_bit_end && w_last_stop && !fifo_empty);

    always_comb begin
        w_par_xor = 1'b0;
        for (int i = 0; i < MAX_DATA_LEN; i++) begin
            if (4'(i) < w_len) w_par_xor = w_par_xor ^ w_fifo_rdata[i];
        end
    end

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            shift_q    <= '0;
            len_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            two_stop_q <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            shift_q    <= shift_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            two_stop_q <= two_stop_d;
            overflow_q <= overflow_d;
`ifdef UART_TX_BREAK_EN
            brk_q      <= brk_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        shift_d    = shift_q;
        len_d      = len_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        two_stop_d = two_stop_q;
        overflow_d = overflow_q | (send & fifo_full);
`ifdef UART_TX_BREAK_EN
        brk_d      = brk_q;
`endif

        if (state_q != ST_IDLE) baud_d = w_bit_end ? '0 : baud_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
`ifdef UART_TX_BREAK_EN
                if (send_break) begin
                    brk_d = 1'b1;
                end else if (brk_q) begin
                    baud_d = w_bit_end ? '0 : baud_q + 1'b1;
                    if (w_bit_end) brk_d = 1'b0;
                end
`endif
            end
            ST_START: begin
                if (w_bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == len_q - 4'd1) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (!w_last_stop) stop_d  = 1'b1;
                    else              state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame load overrides the per-state update, giving gapless back-to-back frames.
        if (w_pop) begin
            state_d    = ST_START;
            baud_d     = '0;
            bit_d      = '0;
            stop_d     = 1'b0;
            shift_d    = w_fifo_rdata;
            len_d      = w_len;
            par_en_d   = parity_en;
            par_bit_d  = w_par_xor ^ (parity_type == PARITY_ODD);
            two_stop_d = two_stop;
`ifdef UART_TX_BREAK_EN
            brk_d      = 1'b0;
`endif
        end
    end

    always_comb begin
        tx_serialout = 1'b1;
        tx_busy      = 1'b1;
        tx_done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_busy = 1'b0;
`ifdef UART_TX_BREAK_EN
                tx_serialout = ~send_break;
`endif
            end
            ST_START:  tx_serialout = 1'b0;
            ST_DATA:   tx_serialout = shift_q[0];
            ST_PARITY: tx_serialout = par_bit_q;
            ST_STOP:   tx_done      = w_bit_end && w_last_stop;
            default:   tx_busy      = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffered
// Brief    : Directed self-checking bench for uart_tx_buffered (CLKS_PER_BIT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    localparam int c_clks = 4;

    logic       tx_clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] parallel_datain = '0;
    logic       send = 1'b0;
    logic [3:0] data_len = 4'd8;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic       two_stop = 1'b0;
`ifdef UART_TX_BREAK_EN
    logic       send_break = 1'b0;
`endif
    logic       tx_serialout;
    logic       tx_busy;
    logic       tx_done;
    logic       fifo_full;
    logic       fifo_empty;
    logic [3:0] fifo_count;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 tx_clk = ~tx_clk;

    uart_tx_buffered #(
        .MAX_DATA_LEN (9),
        .FIFO_DEPTH   (8),
        .CLKS_PER_BIT (c_clks)
    ) dut (
        .tx_clk          (tx_clk),
        .rst             (rst),
        .parallel_datain (parallel_datain),
        .send            (send),
        .data_len        (data_len),
        .parity_en       (parity_en),
        .parity_type     (parity_type),
        .two_stop        (two_stop),
`ifdef UART_TX_BREAK_EN
        .send_break      (send_break),
`endif
        .tx_serialout    (tx_serialout),
        .tx_busy         (tx_busy),
        .tx_done         (tx_done),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .fifo_count      (fifo_count),
        .overflow        (overflow)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge tx_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [8:0] w);
        send = 1'b1;
        parallel_datain = w;
        tick(1);
        send = 1'b0;
    endtask

    // Waits (bounded) for START, then samples each bit mid-way and notes tx_done.
    task automatic run_frame(input int nbits, input int toggle_at,
                             output logic [15:0] bits, output int waited,
                             output int done_at, output int ndone);
        waited = 0;
        while (!(tx_busy && tx_serialout == 1'b0) && waited < 200) begin
            tick(1);
            waited++;
        end
        bits = '0;
        done_at = -1;
        ndone = 0;
        for (int c = 0; c < nbits * c_clks; c++) begin
            if (c % c_clks == 1) bits[c / c_clks] = tx_serialout;
            if (tx_done) begin
                ndone++;
                done_at = c;
            end
            if (c == toggle_at) parity_en = ~parity_en;
            if (c != nbits * c_clks - 1) tick(1);
        end
    endtask

    initial begin
        logic [15:0] bits;
        int          waited, done_at, ndone, n, pulses, busy_cycles;

        // Reset state
        tick(2);
        check("rst_serialout", 32'(tx_serialout), 32'd1);
        check("rst_busy",      32'(tx_busy),      32'd0);
        check("rst_done",      32'(tx_done),      32'd0);
        check("rst_count",     32'(fifo_count),   32'd0);
        check("rst_empty",     32'(fifo_empty),   32'd1);
        check("rst_full",      32'(fifo_full),    32'd0);
        check("rst_overflow",  32'(overflow),     32'd0);
        rst = 1'b0;
        tick(1);

        // 8 data bits, even parity, 0x01
        data_len = 4'd8; parity_en = 1'b1; parity_type = 1'b0; two_stop = 1'b0;
        push_word(9'h001);
        check("t1_count_after_push", 32'(fifo_count), 32'd1);
        check("t1_idle_busy",        32'(tx_busy),    32'd0);
        run_frame(11, -1, bits, waited, done_at, ndone);
        check("t1_bits",    32'(bits),  32'h602);
        check("t1_done_at", done_at,    32'd43);
        check("t1_ndone",   ndone,      32'd1);

        // Odd parity, two stop bits, 0x03
        parity_type = 1'b1; two_stop = 1'b1;
        push_word(9'h003);
        run_frame(12, -1, bits, waited, done_at, ndone);
        check("t2_bits",    32'(bits), 32'hE06);
        check("t2_done_at", done_at,   32'd47);
        two_stop = 1'b0; parity_type = 1'b0;

        // 5 data bits, no parity, upper bits ignored
        data_len = 4'd5; parity_en = 1'b0;
        push_word(9'h1FF);
        run_frame(7, -1, bits, waited, done_at, ndone);
        check("t3_bits",    32'(bits), 32'h07E);
        check("t3_done_at", done_at,   32'd27);
        tick(1);
        check("t3_idle_line", 32'(tx_serialout), 32'd1);
        check("t3_idle_busy", 32'(tx_busy),      32'd0);

        // data_len above maximum saturates to 9
        data_len = 4'd15;
        push_word(9'h155);
        run_frame(11, -1, bits, waited, done_at, ndone);
        check("clamp_hi_bits",    32'(bits), 32'h6AA);
        check("clamp_hi_done_at", done_at,   32'd43);

        // data_len below minimum saturates to 5; parity only over those 5 bits
        data_len = 4'd2; parity_en = 1'b1; parity_type = 1'b0;
        push_word(9'h033);
        run_frame(8, -1, bits, waited, done_at, ndone);
        check("clamp_lo_bits",    32'(bits), 32'h0E6);
        check("clamp_lo_done_at", done_at,   32'd31);
        tick(1);

        // Fill FIFO, overflow, then gapless drain
        data_len = 4'd5; parity_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send = 1'b1;
            parallel_datain = (i == 9) ? 9'h01F : 9'(9'h100 | i);
            tick(1);
            if (i == 1) check("t4_push_pop_count", 32'(fifo_count), 32'd1);
            if (i == 8) begin
                check("t4_full_count", 32'(fifo_count), 32'd8);
                check("t4_full",       32'(fifo_full),  32'd1);
                check("t4_no_ovf_yet", 32'(overflow),   32'd0);
            end
        end
        send = 1'b0;
        check("t4_overflow",       32'(overflow),   32'd1);
        check("t4_count_after_ovf", 32'(fifo_count), 32'd8);
        n = 0;
        while (!tx_done && n < 200) begin
            tick(1);
            n++;
        end
        check("t4_frame0_end", n, 32'd19);
        pulses = 1;
        for (int i = 1; i < 9; i++) begin
            run_frame(7, -1, bits, waited, done_at, ndone);
            pulses += ndone;
            check($sformatf("t4_gap_%0d", i),  waited,    32'd1);
            check($sformatf("t4_bits_%0d", i), 32'(bits), 32'(64 | (i << 1)));
            check($sformatf("t4_done_%0d", i), done_at,   32'd27);
        end
        check("t4_pulses", pulses, 32'd9);
        tick(1);
        check("t4_drained_busy",  32'(tx_busy),    32'd0);
        check("t4_drained_empty", 32'(fifo_empty), 32'd1);
        check("t4_ovf_sticky",    32'(overflow),   32'd1);

        // Reset mid-DATA of second frame
        data_len = 4'd8; parity_en = 1'b0;
        push_word(9'h0AA);
        push_word(9'h055);
        push_word(9'h0F0);
        n = 0;
        while (!tx_done && n < 200) begin
            tick(1);
            n++;
        end
        check("t5_first_done_seen", 32'(n < 200), 32'd1);
        tick(1 + c_clks + 5);
        check("t5_mid_frame_busy", 32'(tx_busy),    32'd1);
        check("t5_queued_count",   32'(fifo_count), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t5_line_high", 32'(tx_serialout), 32'd1);
        check("t5_count",     32'(fifo_count),   32'd0);
        check("t5_busy",      32'(tx_busy),      32'd0);
        check("t5_overflow",  32'(overflow),     32'd0);
        pulses = 0;
        busy_cycles = 0;
        for (int c = 0; c < 100; c++) begin
            tick(1);
            if (tx_done) pulses++;
            if (tx_busy) busy_cycles++;
        end
        check("t5_no_done", pulses,      32'd0);
        check("t5_no_busy", busy_cycles, 32'd0);

        // Toggle parity_en mid-frame with a second frame queued
        data_len = 4'd8; parity_en = 1'b1; parity_type = 1'b0;
        push_word(9'h001);
        push_word(9'h001);
        run_frame(11, 10, bits, waited, done_at, ndone);
        check("t6_f1_bits",    32'(bits), 32'h602);
        check("t6_f1_done_at", done_at,   32'd43);
        run_frame(10, -1, bits, waited, done_at, ndone);
        check("t6_f2_gap",     waited,    32'd1);
        check("t6_f2_bits",    32'(bits), 32'h202);
        check("t6_f2_done_at", done_at,   32'd39);
        tick(1);
        check("t6_idle", 32'(tx_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
